// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: two-requester round-robin arbiter steering a 2:1 mux into a
// registered output slot with valid/ready handshake toward one consumer.
//
// Handshakes:
//   requester side  - req/gnt: a requester holds req and data stable until it
//                     sees gnt high; the word is captured at the edge that
//                     ends the gnt cycle.
//   consumer side   - valid/ready: y is transferred on every edge where
//                     out_valid=1 and out_ready=1; y/sel/out_valid do not
//                     change while out_valid=1 and out_ready=0.
module rr_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // last granted requester; reset to 1 so requester 0 wins the first tie
  logic last;

  logic load;
  logic any_req;
  logic winner;
  logic grant;

  // Arbitration and next state: slot can load when empty or being drained
  always_comb begin
    load       = (state == IDLE) | out_ready;
    any_req    = req0 | req1;
    winner     = 1'b0;
    state_next = state;
    if (req0 && req1) begin
      winner = ~last;
    end else begin
      winner = req1;
    end
    // gating with rst_n keeps grants low for the whole reset interval
    grant = rst_n & load & any_req;
    gnt0  = grant & ~winner;
    gnt1  = grant & winner;
    if (load) begin
      if (any_req) begin
        state_next = winner ? HOLD1 : HOLD0;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output slot and priority pointer: update only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= '0;
      sel  <= 1'b0;
      last <= 1'b1;
    end else if (grant) begin
      y    <= winner ? d1 : d0;
      sel  <= winner;
      last <= winner;
    end
  end

  // Valid is a decode of the state register so reset clears it at once
  always_comb begin
    out_valid = (state != IDLE);
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed test of rr_mux_arbiter with hand-computed
// expectations for reset, single requester, tie alternation, backpressure,
// priority memory across idle, and reset recovery.
module tb_rr_mux_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             req0;
  logic [WIDTH-1:0] d0;
  logic             req1;
  logic [WIDTH-1:0] d1;
  logic             out_ready;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] y;

  int n_tests;
  int n_fail;

  logic [WIDTH-1:0] exp_q[$];

  rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .d0        (d0),
    .req1      (req1),
    .d1        (d1),
    .out_ready (out_ready),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .y         (y)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic g0, input logic g1);
    #1;
    check({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, g0});
    check({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, g1});
  endtask

  task automatic check_out(input string tag, input logic v, input logic s, input logic [WIDTH-1:0] yv);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_sel"}, {31'd0, sel}, {31'd0, s});
    check({tag, "_y"}, {24'd0, y}, {24'd0, yv});
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req0      = 1'b1;
    req1      = 1'b0;
    d0        = 8'h00;
    d1        = 8'h00;
    out_ready = 1'b1;

    // reset state, with a request present to show grants are gated
    repeat (2) tick();
    check_gnt("rst", 1'b0, 1'b0);
    check_out("rst", 1'b0, 1'b0, 8'h00);
    tick();
    req0  = 1'b0;
    rst_n = 1'b1;

    // single requester
    tick();
    req0 = 1'b1;
    d0   = 8'hA5;
    check_gnt("single", 1'b1, 1'b0);
    tick();
    check_out("single_cap", 1'b1, 1'b0, 8'hA5);
    req0 = 1'b0;
    check_gnt("single_drop", 1'b0, 1'b0);
    tick();
    check_out("single_idle", 1'b0, 1'b0, 8'hA5);

    // tie and alternation from reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    req0 = 1'b1;
    req1 = 1'b1;
    d0   = 8'h11;
    d1   = 8'h22;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    for (int i = 0; i < 5; i++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      check_gnt($sformatf("alt%0d", i), (i % 2) == 0, (i % 2) == 1);
      check($sformatf("alt%0d_onehot", i), {31'd0, gnt0 & gnt1}, 32'd0);
      tick();
      check_out($sformatf("alt%0d", i), 1'b1, e == 8'h22, e);
    end

    // backpressure: y=0x11 held for 3 cycles, then requester 1 wins
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_gnt($sformatf("bp%0d", i), 1'b0, 1'b0);
      tick();
      check_out($sformatf("bp%0d", i), 1'b1, 1'b0, 8'h11);
    end
    out_ready = 1'b1;
    check_gnt("bp_release", 1'b0, 1'b1);
    tick();
    check_out("bp_release", 1'b1, 1'b1, 8'h22);

    // priority memory across idle: last=1, idle 4 cycles, tie -> gnt0
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_gnt($sformatf("idle%0d", i), 1'b0, 1'b0);
      tick();
    end
    check_out("idle_hold", 1'b0, 1'b1, 8'h22);
    req0 = 1'b1;
    req1 = 1'b1;
    check_gnt("mem_after1", 1'b1, 1'b0);
    tick();
    check_out("mem_after1", 1'b1, 1'b0, 8'h11);

    // now last=0: idle 2 cycles, tie -> gnt1
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) tick();
    req0 = 1'b1;
    req1 = 1'b1;
    check_gnt("mem_after0", 1'b0, 1'b1);
    tick();
    check_out("mem_after0", 1'b1, 1'b1, 8'h22);
    check_gnt("mem_next", 1'b1, 1'b0);
    tick();
    check_out("mem_next", 1'b1, 1'b0, 8'h11);

    // mid-stream asynchronous reset with last=0 and out_valid=1
    #2;
    rst_n = 1'b0;
    #1;
    check_gnt("async_rst", 1'b0, 1'b0);
    check_out("async_rst", 1'b0, 1'b0, 8'h00);
    tick();
    d0    = 8'h5A;
    d1    = 8'hC3;
    rst_n = 1'b1;
    check_gnt("recover", 1'b1, 1'b0);
    tick();
    check_out("recover", 1'b1, 1'b0, 8'h5A);
    check_gnt("recover_next", 1'b0, 1'b1);
    tick();
    check_out("recover_next", 1'b1, 1'b1, 8'hC3);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
